// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: forward-select
// encoding, packed tag layout and the LOAD_AVAIL legality check.
package pipe_hazard_ctrl_pkg;

  // Forward select 0 always means "use the ID/EX register value".
  localparam int unsigned FwdRegfile = 0;

  // Packed tag layout: single-bit flags at the bottom, then rd, rs1, rs2.
  localparam int unsigned TagValid    = 0;
  localparam int unsigned TagRegwrite = 1;
  localparam int unsigned TagIsLoad   = 2;
  localparam int unsigned TagIsMem    = 3;
  localparam int unsigned TagRs1Used  = 4;
  localparam int unsigned TagRs2Used  = 5;
  localparam int unsigned TagRdLsb    = 6;

  function automatic int unsigned tag_rs1_lsb(input int unsigned ra_w);
    return TagRdLsb + ra_w;
  endfunction

  function automatic int unsigned tag_rs2_lsb(input int unsigned ra_w);
    return TagRdLsb + 2 * ra_w;
  endfunction

  function automatic int unsigned tag_width(input int unsigned ra_w);
    return TagRdLsb + 3 * ra_w;
  endfunction

  // A load result must become forwardable somewhere in the post-EX stages.
  function automatic bit load_avail_legal(input int unsigned load_avail,
                                          input int unsigned post_stages);
    return (load_avail >= 1) && (load_avail <= post_stages);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_tag_stage.sv
// One pipeline tag register: synchronous active-low reset, flush beats write.
module pipe_hazard_ctrl_tag_stage
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned Width = tag_width(5)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic             flush_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] q_d, q_q;

  // Next tag: a flushed slot becomes an all-zero bubble, otherwise load or hold.
  always_comb begin
    q_d = q_q;
    if (flush_i) begin
      q_d = '0;
    end else if (we_i) begin
      q_d = d_i;
    end
  end

  // Tag register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for an IF-ID-EX core followed by POST_STAGES post-EX
// stages: load-use stall, redirect flush, memory-wait freeze, EX forwarding
// and a saturating stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned POST_STAGES = 2,
  parameter int unsigned LOAD_AVAIL  = 2,
  parameter int unsigned RA_W        = 5,
  parameter int unsigned CNT_W       = 32,
  localparam int unsigned FW         = $clog2(POST_STAGES + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             id_valid_i,
  input  logic             id_regwrite_i,
  input  logic             id_is_load_i,
  input  logic             id_is_mem_i,
  input  logic [RA_W-1:0]  id_rs1_i,
  input  logic [RA_W-1:0]  id_rs2_i,
  input  logic [RA_W-1:0]  id_rd_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic             ex_redirect_i,
  input  logic             mem_ready_i,
  output logic             pc_we_o,
  output logic             ifid_we_o,
  output logic             ifid_flush_o,
  output logic             idex_we_o,
  output logic             idex_flush_o,
  output logic             post_we_o,
  output logic [FW-1:0]    fwd_a_o,
  output logic [FW-1:0]    fwd_b_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int unsigned NStages = POST_STAGES + 1;  // index 0 = EX
  localparam int unsigned TW      = tag_width(RA_W);
  localparam int unsigned Rs1Lsb  = tag_rs1_lsb(RA_W);
  localparam int unsigned Rs2Lsb  = tag_rs2_lsb(RA_W);

  if (!load_avail_legal(LOAD_AVAIL, POST_STAGES)) begin : g_bad_load_avail
    $error("pipe_hazard_ctrl: LOAD_AVAIL must lie in 1..POST_STAGES");
  end

  logic [TW-1:0]      id_tag;
  logic [TW-1:0]      tag_d [NStages];
  logic [TW-1:0]      tag_q [NStages];
  logic [NStages-1:0] st_we, st_flush;
  logic [NStages-1:0] st_valid, st_rw, st_load;
  logic [RA_W-1:0]    st_rd [NStages];
  logic [RA_W-1:0]    ex_rs1, ex_rs2;
  logic               ex_rs1_used, ex_rs2_used;
  logic               unused_tag;
  logic               freeze, load_use;
  logic               hit_a, hit_b;
  logic [CNT_W-1:0]   cnt_d, cnt_q;

  // Pack the ID instruction attributes into a tag for the EX slot.
  always_comb begin
    id_tag                     = '0;
    id_tag[TagValid]           = id_valid_i;
    id_tag[TagRegwrite]        = id_regwrite_i;
    id_tag[TagIsLoad]          = id_is_load_i;
    id_tag[TagIsMem]           = id_is_mem_i;
    id_tag[TagRs1Used]         = id_rs1_used_i;
    id_tag[TagRs2Used]         = id_rs2_used_i;
    id_tag[TagRdLsb +: RA_W]   = id_rd_i;
    id_tag[Rs1Lsb +: RA_W]     = id_rs1_i;
    id_tag[Rs2Lsb +: RA_W]     = id_rs2_i;
  end

  // Stage chaining: EX loads from ID, each post stage from its predecessor.
  always_comb begin
    tag_d[0]    = id_tag;
    st_we[0]    = idex_we_o;
    st_flush[0] = idex_flush_o;
    for (int unsigned s = 1; s < NStages; s++) begin
      tag_d[s]    = tag_q[s-1];
      st_we[s]    = post_we_o;
      st_flush[s] = 1'b0;
    end
  end

  for (genvar s = 0; s < NStages; s++) begin : g_stage
    pipe_hazard_ctrl_tag_stage #(
      .Width (TW)
    ) u_tag (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .we_i    (st_we[s]),
      .flush_i (st_flush[s]),
      .d_i     (tag_d[s]),
      .q_o     (tag_q[s])
    );
  end

  // Unpack tag fields; post-stage source fields are carried but never read.
  always_comb begin
    unused_tag = 1'b0;
    for (int unsigned s = 0; s < NStages; s++) begin
      st_valid[s] = tag_q[s][TagValid];
      st_rw[s]    = tag_q[s][TagRegwrite];
      st_load[s]  = tag_q[s][TagIsLoad];
      st_rd[s]    = tag_q[s][TagRdLsb +: RA_W];
      unused_tag  = unused_tag ^ (^tag_q[s]);
    end
    ex_rs1      = tag_q[0][Rs1Lsb +: RA_W];
    ex_rs2      = tag_q[0][Rs2Lsb +: RA_W];
    ex_rs1_used = tag_q[0][TagRs1Used];
    ex_rs2_used = tag_q[0][TagRs2Used];
    freeze      = tag_q[1][TagValid] & tag_q[1][TagIsMem] & ~mem_ready_i;
  end

  // Load-use: a load in stage j is not forwardable in time while j+1 < LOAD_AVAIL.
  always_comb begin
    load_use = 1'b0;
    for (int unsigned j = 0; j < NStages; j++) begin
      if ((j + 1 < LOAD_AVAIL) && st_valid[j] && st_rw[j] && st_load[j]) begin
        if (id_valid_i && id_rs1_used_i && (id_rs1_i != '0) && (st_rd[j] == id_rs1_i)) begin
          load_use = 1'b1;
        end
        if (id_valid_i && id_rs2_used_i && (id_rs2_i != '0) && (st_rd[j] == id_rs2_i)) begin
          load_use = 1'b1;
        end
      end
    end
  end

  // Pipeline controls, priority: memory freeze > redirect > load-use stall.
  always_comb begin
    pc_we_o      = 1'b1;
    ifid_we_o    = 1'b1;
    ifid_flush_o = 1'b0;
    idex_we_o    = 1'b1;
    idex_flush_o = 1'b0;
    post_we_o    = 1'b1;
    if (freeze) begin
      pc_we_o   = 1'b0;
      ifid_we_o = 1'b0;
      idex_we_o = 1'b0;
      post_we_o = 1'b0;
    end else if (ex_redirect_i) begin
      ifid_flush_o = 1'b1;
      idex_flush_o = 1'b1;
    end else if (load_use) begin
      pc_we_o      = 1'b0;
      ifid_we_o    = 1'b0;
      idex_flush_o = 1'b1;
    end
  end

  // Forward selects: youngest (smallest-index) ready producer wins.
  always_comb begin
    fwd_a_o = FW'(FwdRegfile);
    fwd_b_o = FW'(FwdRegfile);
    hit_a   = 1'b0;
    hit_b   = 1'b0;
    for (int unsigned k = 1; k < NStages; k++) begin
      if (st_valid[k] && st_rw[k] && (!st_load[k] || (k >= LOAD_AVAIL))) begin
        if (!hit_a && ex_rs1_used && (ex_rs1 != '0) && (st_rd[k] == ex_rs1)) begin
          fwd_a_o = FW'(k);
          hit_a   = 1'b1;
        end
        if (!hit_b && ex_rs2_used && (ex_rs2 != '0) && (st_rd[k] == ex_rs2)) begin
          fwd_b_o = FW'(k);
          hit_b   = 1'b1;
        end
      end
    end
  end

  // Stall counter next state: count cycles with the PC held, saturate at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (!pc_we_o && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Stall counter register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a default instance (2 post stages,
// LOAD_AVAIL 2) and a deep instance (3 post stages, LOAD_AVAIL 3) share inputs.
module tb_pipe_hazard_ctrl;

  logic       clk, rst_n;
  logic       id_valid, id_regwrite, id_is_load, id_is_mem, id_rs1_used, id_rs2_used;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       ex_redirect, mem_ready;

  logic        pc_we, ifid_we, ifid_flush, idex_we, idex_flush, post_we;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] stall_cnt;
  logic        pc_we3, ifid_we3, ifid_flush3, idex_we3, idex_flush3, post_we3;
  logic [1:0]  fwd_a3, fwd_b3;
  logic [31:0] stall_cnt3;

  logic [5:0] ctrl, ctrl3;
  assign ctrl  = {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, post_we};
  assign ctrl3 = {pc_we3, ifid_we3, ifid_flush3, idex_we3, idex_flush3, post_we3};

  localparam logic [5:0] CNorm = 6'b110101;
  localparam logic [5:0] CLu   = 6'b000111;
  localparam logic [5:0] CRedir = 6'b111111;
  localparam logic [5:0] CFrz  = 6'b000000;

  int tests = 0;
  int fails = 0;

  pipe_hazard_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n),
    .id_valid_i(id_valid), .id_regwrite_i(id_regwrite), .id_is_load_i(id_is_load),
    .id_is_mem_i(id_is_mem), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd),
    .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
    .ex_redirect_i(ex_redirect), .mem_ready_i(mem_ready),
    .pc_we_o(pc_we), .ifid_we_o(ifid_we), .ifid_flush_o(ifid_flush),
    .idex_we_o(idex_we), .idex_flush_o(idex_flush), .post_we_o(post_we),
    .fwd_a_o(fwd_a), .fwd_b_o(fwd_b), .stall_cnt_o(stall_cnt)
  );

  pipe_hazard_ctrl #(.POST_STAGES(3), .LOAD_AVAIL(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .id_valid_i(id_valid), .id_regwrite_i(id_regwrite), .id_is_load_i(id_is_load),
    .id_is_mem_i(id_is_mem), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd),
    .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
    .ex_redirect_i(ex_redirect), .mem_ready_i(mem_ready),
    .pc_we_o(pc_we3), .ifid_we_o(ifid_we3), .ifid_flush_o(ifid_flush3),
    .idex_we_o(idex_we3), .idex_flush_o(idex_flush3), .post_we_o(post_we3),
    .fwd_a_o(fwd_a3), .fwd_b_o(fwd_b3), .stall_cnt_o(stall_cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_id(input logic v, input logic rw, input logic ld, input logic mem,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2);
    id_valid = v; id_regwrite = rw; id_is_load = ld; id_is_mem = mem;
    id_rd = rd; id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = u1; id_rs2_used = u2;
  endtask

  task automatic clear_id();
    set_id(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  // Advance to just after the next rising edge.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; clear_id(); ex_redirect = 1'b0; mem_ready = 1'b1;
    nxt();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    tests++; if (ctrl !== CNorm) begin fails++; $display("FAIL reset_ctrl: got %b want %b", ctrl, CNorm); end
    tests++; if (fwd_a !== 2'd0) begin fails++; $display("FAIL reset_fwd_a: got %0d want 0", fwd_a); end
    tests++; if (fwd_b !== 2'd0) begin fails++; $display("FAIL reset_fwd_b: got %0d want 0", fwd_b); end
    tests++; if (stall_cnt !== 32'd0) begin fails++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
    tests++; if (ctrl3 !== CNorm) begin fails++; $display("FAIL reset_ctrl3: got %b want %b", ctrl3, CNorm); end
    tests++; if (stall_cnt3 !== 32'd0) begin fails++; $display("FAIL reset_cnt3: got %0d want 0", stall_cnt3); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_id(1, 1, 0, 0, 5'd1, 5'd3, 5'd4, 1, 1);          // add x1,x3,x4
    nxt();
    set_id(1, 1, 0, 0, 5'd2, 5'd1, 5'd3, 1, 1);          // add x2,x1,x3
    #1;
    tests++; if (ctrl !== CNorm) begin fails++; $display("FAIL b2b_nostall: got %b want %b", ctrl, CNorm); end
    nxt();
    set_id(1, 1, 0, 0, 5'd7, 5'd0, 5'd0, 0, 0);          // producer of x7
    #1;
    tests++; if (fwd_a !== 2'd1) begin fails++; $display("FAIL b2b_fwd_a: got %0d want 1", fwd_a); end
    tests++; if (fwd_b !== 2'd0) begin fails++; $display("FAIL b2b_fwd_b: got %0d want 0", fwd_b); end
    nxt();
    set_id(1, 1, 0, 0, 5'd8, 5'd9, 5'd10, 1, 1);         // independent, writes x8
    nxt();
    set_id(1, 1, 0, 0, 5'd9, 5'd7, 5'd8, 1, 1);          // add x9,x7,x8
    nxt();
    clear_id();
    #1;
    tests++; if (fwd_a !== 2'd2) begin fails++; $display("FAIL gap_fwd_a: got %0d want 2", fwd_a); end
    tests++; if (fwd_b !== 2'd1) begin fails++; $display("FAIL gap_fwd_b: got %0d want 1", fwd_b); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1, 1, 1, 1, 5'd5, 5'd2, 5'd0, 1, 0);          // lw x5
    nxt();
    set_id(1, 1, 0, 0, 5'd6, 5'd5, 5'd5, 1, 1);          // add x6,x5,x5
    #1;
    tests++; if (ctrl !== CLu) begin fails++; $display("FAIL lu_ctrl: got %b want %b", ctrl, CLu); end
    tests++; if (stall_cnt !== 32'd0) begin fails++; $display("FAIL lu_cnt0: got %0d want 0", stall_cnt); end
    nxt();
    #1;
    tests++; if (ctrl !== CNorm) begin fails++; $display("FAIL lu_release: got %b want %b", ctrl, CNorm); end
    tests++; if (stall_cnt !== 32'd1) begin fails++; $display("FAIL lu_cnt1: got %0d want 1", stall_cnt); end
    nxt();
    clear_id();
    #1;
    tests++; if (fwd_a !== 2'd2) begin fails++; $display("FAIL lu_fwd_a: got %0d want 2", fwd_a); end
    tests++; if (fwd_b !== 2'd2) begin fails++; $display("FAIL lu_fwd_b: got %0d want 2", fwd_b); end
    tests++; if (stall_cnt !== 32'd1) begin fails++; $display("FAIL lu_cnt_hold: got %0d want 1", stall_cnt); end
  endtask

  task automatic test_x0();
    do_reset();
    set_id(1, 1, 0, 0, 5'd0, 5'd1, 5'd0, 1, 0);          // addi x0,x1,imm
    nxt();
    set_id(1, 1, 0, 0, 5'd3, 5'd0, 5'd0, 1, 1);          // uses x0
    #1;
    tests++; if (ctrl !== CNorm) begin fails++; $display("FAIL x0_nostall: got %b want %b", ctrl, CNorm); end
    nxt();
    set_id(1, 1, 1, 1, 5'd0, 5'd2, 5'd0, 1, 0);          // lw x0
    #1;
    tests++; if (fwd_a !== 2'd0) begin fails++; $display("FAIL x0_fwd_a: got %0d want 0", fwd_a); end
    tests++; if (fwd_b !== 2'd0) begin fails++; $display("FAIL x0_fwd_b: got %0d want 0", fwd_b); end
    nxt();
    set_id(1, 1, 0, 0, 5'd4, 5'd0, 5'd0, 1, 1);          // uses x0 after lw x0
    #1;
    tests++; if (ctrl !== CNorm) begin fails++; $display("FAIL x0_load_nostall: got %b want %b", ctrl, CNorm); end
    tests++; if (stall_cnt !== 32'd0) begin fails++; $display("FAIL x0_cnt: got %0d want 0", stall_cnt); end
  endtask

  task automatic test_redirect_load_use();
    do_reset();
    set_id(1, 1, 1, 1, 5'd5, 5'd2, 5'd0, 1, 0);          // lw x5
    nxt();
    set_id(1, 1, 0, 0, 5'd6, 5'd5, 5'd5, 1, 1);
    ex_redirect = 1'b1;
    #1;
    tests++; if (ctrl !== CRedir) begin fails++; $display("FAIL redir_ctrl: got %b want %b", ctrl, CRedir); end
    nxt();
    ex_redirect = 1'b0;
    clear_id();
    #1;
    tests++; if (ctrl !== CNorm) begin fails++; $display("FAIL redir_after: got %b want %b", ctrl, CNorm); end
    tests++; if (stall_cnt !== 32'd0) begin fails++; $display("FAIL redir_cnt: got %0d want 0", stall_cnt); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    set_id(1, 0, 0, 1, 5'd0, 5'd2, 5'd3, 1, 1);          // sw
    nxt();
    set_id(1, 0, 0, 0, 5'd0, 5'd4, 5'd5, 1, 1);          // branch
    nxt();
    set_id(1, 1, 0, 0, 5'd6, 5'd7, 5'd8, 1, 1);
    mem_ready   = 1'b0;
    ex_redirect = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (ctrl !== CFrz) begin fails++; $display("FAIL frz_ctrl%0d: got %b want %b", i, ctrl, CFrz); end
      tests++; if (stall_cnt !== 32'(i)) begin fails++; $display("FAIL frz_cnt%0d: got %0d want %0d", i, stall_cnt, i); end
      nxt();
    end
    mem_ready = 1'b1;
    #1;
    tests++; if (ctrl !== CRedir) begin fails++; $display("FAIL frz_redir: got %b want %b", ctrl, CRedir); end
    tests++; if (stall_cnt !== 32'd3) begin fails++; $display("FAIL frz_cnt3: got %0d want 3", stall_cnt); end
    nxt();
    ex_redirect = 1'b0;
    clear_id();
    #1;
    tests++; if (ctrl !== CNorm) begin fails++; $display("FAIL frz_after: got %b want %b", ctrl, CNorm); end
  endtask

  task automatic test_deep_load();
    do_reset();
    set_id(1, 1, 1, 1, 5'd5, 5'd2, 5'd0, 1, 0);          // lw x5
    nxt();
    set_id(1, 1, 0, 0, 5'd6, 5'd5, 5'd5, 1, 1);
    #1;
    tests++; if (ctrl3 !== CLu) begin fails++; $display("FAIL deep_stall1: got %b want %b", ctrl3, CLu); end
    nxt();
    #1;
    tests++; if (ctrl3 !== CLu) begin fails++; $display("FAIL deep_stall2: got %b want %b", ctrl3, CLu); end
    tests++; if (stall_cnt3 !== 32'd1) begin fails++; $display("FAIL deep_cnt1: got %0d want 1", stall_cnt3); end
    nxt();
    #1;
    tests++; if (ctrl3 !== CNorm) begin fails++; $display("FAIL deep_release: got %b want %b", ctrl3, CNorm); end
    tests++; if (stall_cnt3 !== 32'd2) begin fails++; $display("FAIL deep_cnt2: got %0d want 2", stall_cnt3); end
    nxt();
    clear_id();
    #1;
    tests++; if (fwd_a3 !== 2'd3) begin fails++; $display("FAIL deep_fwd_a: got %0d want 3", fwd_a3); end
    tests++; if (fwd_b3 !== 2'd3) begin fails++; $display("FAIL deep_fwd_b: got %0d want 3", fwd_b3); end
    nxt();
    set_id(1, 1, 1, 1, 5'd5, 5'd2, 5'd0, 1, 0);
    nxt();
    set_id(1, 1, 0, 0, 5'd6, 5'd5, 5'd5, 1, 1);
    nxt();
    #1;
    tests++; if (ctrl3 !== CLu) begin fails++; $display("FAIL deep2_stall2: got %b want %b", ctrl3, CLu); end
    tests++; if (stall_cnt3 !== 32'd3) begin fails++; $display("FAIL deep2_cnt: got %0d want 3", stall_cnt3); end
    rst_n = 1'b0;                                         // reset mid-stall
    nxt();
    rst_n = 1'b1;
    #1;
    tests++; if (stall_cnt3 !== 32'd0) begin fails++; $display("FAIL deep_rst_cnt: got %0d want 0", stall_cnt3); end
    tests++; if (pc_we3 !== 1'b1) begin fails++; $display("FAIL deep_rst_pcwe: got %b want 1", pc_we3); end
    tests++; if (ctrl3 !== CNorm) begin fails++; $display("FAIL deep_rst_ctrl: got %b want %b", ctrl3, CNorm); end
  endtask

  initial begin
    rst_n = 1'b0; ex_redirect = 1'b0; mem_ready = 1'b1;
    clear_id();
    test_reset();
    test_back_to_back();
    test_load_use();
    test_x0();
    test_redirect_load_use();
    test_mem_wait();
    test_deep_load();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised pipeline hazard controller for the pipelined RISC-V core: generalises the fixed 5-stage stall/flush/forward logic to an IF–ID–EX core followed by `POST_STAGES` post-EX stages. It tracks in-flight destination tags and emits per-stage write enables and flushes. It also emits forward selects for both EX operands, with configurable load latency and a memory-wait freeze driven by the memory ready handshake. It also keeps a saturating stall-cycle counter for performance debug.

## Interface
- `POST_STAGES`, 2: number of stages after EX; stage 1 = MEM, stage `POST_STAGES` = WB (register-file write).
- `LOAD_AVAIL`, 2: first post-EX stage whose load result is forwardable; legal range 1..`POST_STAGES`.
- `RA_W`, 5: register address width.
- `CNT_W`, 32: stall counter width.
- `clk` in 1: clock; the block uses only this one clock.
- `rst` in 1: synchronous reset, active-low.
- `id_valid`, `id_regwrite`, `id_is_load`, `id_is_mem` in 1 each: attributes of the instruction in ID.
- `id_rs1`, `id_rs2`, `id_rd` in `RA_W`: ID register addresses.
- `id_rs1_used`, `id_rs2_used` in 1: operand actually read.
- `ex_redirect` in 1: taken branch or jump resolved in EX.
- `mem_ready` in 1: memory ready handshake; low stalls a memory op in post stage 1.
- `pc_we`, `ifid_we`, `ifid_flush`, `idex_we`, `idex_flush`, `post_we` out 1: pipeline register controls.
- `fwd_a`, `fwd_b` out `FW`=$clog2(`POST_STAGES`+1): EX operand source; 0 = ID/EX register value, k = result of post stage k.
- `stall_cnt` out `CNT_W`: saturating count of cycles with `pc_we`=0.

## Operation
- Internal tag per stage EX and post 1..`POST_STAGES` holds: valid, rd, regwrite, is_load, is_mem. The EX tag also holds rs1/rs2 and their used flags.
- Tags advance on the enables this block generates. A flushed or bubbled slot clears valid.
- Forwarding, for operand a and likewise b:
  - Matching producer: EX rs used, rs ≠ 0, valid, regwrite, rd == rs, and (not is_load or stage ≥ `LOAD_AVAIL`).
  - `fwd_a` = index of the smallest matching stage k, else 0.
- Load-use stall: an ID operand (used, ≠0) matches rd of a valid regwrite load in EX (index 0) or in post stage j with j+1 < `LOAD_AVAIL`.
  - On stall: `pc_we`=0, `ifid_we`=0, `idex_flush`=1.
- Memory wait: post stage 1 valid and is_mem and `mem_ready`=0.
  - All enables are 0 and all flushes are 0; every stage holds.
  - A repeated WB write is idempotent.
- Redirect: `ifid_flush`=1 and `idex_flush`=1, with `pc_we`=1.
- Priority: memory wait > redirect > load-use stall. While frozen, the redirect is held in EX and acted on the first unfrozen cycle. Redirect cancels a coincident load-use stall.
- x0 never forwards and never stalls.
- The register file is write-first; the ID read of a WB-stage producer is covered by the register file, not by this block.

## Timing
- All control and forward outputs are combinational from the current tags and inputs, valid in the same cycle.
- Tags and `stall_cnt` update on the rising `clk` edge.
- Reset (`rst`=0 at an edge):
  - All tag valids clear and `stall_cnt` = 0.
  - Following cycle with no inputs asserted: `pc_we`=`ifid_we`=`idex_we`=`post_we`=1, flushes 0, `fwd_a`=`fwd_b`=0.
- Load-use stall length = max(0, `LOAD_AVAIL` − 1 − j) cycles, where j is the producer stage (0 = EX). With the defaults this is 1 cycle.
- `stall_cnt` increments in every cycle with `pc_we`=0 and holds at all-ones.
- Reset asserted mid-stall or mid-freeze wins over everything. The count restarts from 0.

## Structure
- Shared header/package `pipe_ctrl_def` holds:
  - forward-select encoding (0 = regfile path);
  - tag field widths and bit positions;
  - the legal-range check macro for `LOAD_AVAIL`.
- Sub-module `pipe_tag_stage`: one tag register with we/flush/synchronous active-low reset, instantiated `POST_STAGES`+1 times through generate.
- Match and priority encoding stay in the top level.

## Test plan
- Back-to-back ALU dependence, default params: `add x1`; `add x2,x1,x3` → `fwd_a`=1 in the consumer's EX cycle, no stall. With one independent instruction between them → `fwd_a`=2.
- Load-use: `lw x5`; `add x6,x5,x5` → exactly 1 cycle of `pc_we`=0, `ifid_we`=0, `idex_flush`=1. Then `fwd_a`=`fwd_b`=2, and `stall_cnt` goes 0→1.
- x0 dependence: `addi x0,...` then a use of x0 → `fwd_a`=0, no stall.
- Redirect plus load-use in the same cycle → `ifid_flush`=`idex_flush`=1, `pc_we`=1, `stall_cnt` unchanged.
- `mem_ready`=0 for 3 cycles with `sw` in MEM and `ex_redirect`=1 → all enables 0 for 3 cycles, `stall_cnt` +3. On the 4th cycle the redirect flush fires.
- `POST_STAGES`=3, `LOAD_AVAIL`=3: load then immediate use → 2 stall cycles, then `fwd`=3. `rst`=0 for one cycle during the second stall → tags clear, `stall_cnt`=0, `pc_we`=1 on the next cycle.
